dmem_store_buffer: RTL and testbench

//  Store buffer directly upstream of data_Mem (single port, combinational read, write on posedge clk).

---
 rtl/dmem_store_buffer_if.sv | 33 +++
 rtl/dmem_store_buffer.sv | 67 ++++++
 tb/tb_dmem_store_buffer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_store_buffer_if.sv
// dmem_store_buffer_if: store/load/memory signals between the MEM stage, the store buffer and data memory
//   slave  : the store buffer (drives st_ready, ld_*, mem_* controls, count, empty)
//   master : the pipeline/memory side (drives st_*, ld_valid/ld_addr, mem_rdata)
interface dmem_store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
);
    localparam int CW = $clog2(DEPTH + 1);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_fwd;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] count;
    logic          empty;
    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        output st_ready, ld_data, ld_fwd, mem_read, mem_write, mem_addr, mem_wdata, count, empty
    );
    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        input  st_ready, ld_data, ld_fwd, mem_read, mem_write, mem_addr, mem_wdata, count, empty
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: FIFO store buffer in front of single-port data memory with youngest-match load forwarding
//   clk  : clock, all state updates on posedge
//   rst  : asynchronous active-high reset, discards pending stores
//   sb   : slave modport of dmem_store_buffer_if (store port, load port, data memory port, count/empty)
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input logic               clk,
    input logic               rst,
    dmem_store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
    logic [CW-1:0] count_q, count_d;
    logic          enq, drain, hit;
    logic [DW-1:0] fwd_data;
    assign sb.st_ready  = count_q < CW'(DEPTH);
    assign enq          = sb.st_valid && sb.st_ready;
    // loads own the port; drain only on load-free cycles, never while reset is held
    assign drain        = !rst && !sb.ld_valid && count_q != '0;
    assign sb.mem_read  = !rst && sb.ld_valid;
    assign sb.mem_write = drain;
    assign sb.mem_addr  = rst ? '0 : sb.ld_valid ? sb.ld_addr : drain ? addr_q[head_q] : '0;
    assign sb.mem_wdata = drain ? data_q[head_q] : '0;
    assign sb.ld_data   = (rst || !sb.ld_valid) ? '0 : hit ? fwd_data : sb.mem_rdata;
    assign sb.ld_fwd    = !rst && sb.ld_valid && hit;
    assign sb.count     = count_q;
    assign sb.empty     = count_q == '0;
    // scan oldest to youngest so the last match wins
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q && addr_q[idx] == sb.ld_addr) begin
                hit      = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
    assign head_d  = head_q + PW'(drain);
    assign tail_d  = tail_q + PW'(enq);
    assign count_d = count_q + CW'(enq) - CW'(drain);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= sb.st_addr;
            data_q[tail_q] <= sb.st_data;
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed scenario tests for dmem_store_buffer against a small memory model
module tb_dmem_store_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [15:0] mem [256];
    logic [31:0] wlog [$];
    dmem_store_buffer_if #(.DEPTH(4), .AW(16), .DW(16)) bus ();
    dmem_store_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (.clk(clk), .rst(rst), .sb(bus));
    always #5 clk = ~clk;
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            wlog.push_back({bus.mem_addr, bus.mem_wdata});
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                         input logic lv, input logic [15:0] la);
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
    endtask

    task automatic test_reset();
        int base;
        #1;
        tests++;
        if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.st_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state count=%0d empty=%b st_ready=%b want 0 1 1", bus.count, bus.empty, bus.st_ready);
        end
        tests++;
        if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_addr !== 16'h0 || bus.ld_data !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs mw=%b mr=%b addr=%h ld=%h want 0 0 0 0", bus.mem_write, bus.mem_read, bus.mem_addr, bus.ld_data);
        end
        @(negedge clk);
        rst = 1'b0;
        base = wlog.size();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0050 + 16'(i), 16'hC000 + 16'(i), 1'b1, 16'h0099);
            step();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #1;
        tests++;
        if (bus.count !== 3'd3 || bus.mem_write !== 1'b1) begin
            fails++;
            $display("FAIL reset_prefill count=%0d mw=%b want 3 1", bus.count, bus.mem_write);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
            fails++;
            $display("FAIL reset_async count=%0d empty=%b mw=%b addr=%h wd=%h want 0 1 0 0 0",
                     bus.count, bus.empty, bus.mem_write, bus.mem_addr, bus.mem_wdata);
        end
        step();
        rst = 1'b0;
        step();
        step();
        tests++;
        if (wlog.size() != base || bus.empty !== 1'b1) begin
            fails++;
            $display("FAIL reset_discard writes=%0d empty=%b want 0 1", wlog.size() - base, bus.empty);
        end
    endtask

    task automatic test_store_drain();
        drive(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
        #1;
        tests++;
        if (bus.st_ready !== 1'b1 || bus.mem_write !== 1'b0) begin
            fails++;
            $display("FAIL sd_accept st_ready=%b mw=%b want 1 0", bus.st_ready, bus.mem_write);
        end
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #1;
        tests++;
        if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 16'hBEEF || bus.count !== 3'd1) begin
            fails++;
            $display("FAIL sd_drain mw=%b mr=%b addr=%h wd=%h count=%0d want 1 0 0010 beef 1",
                     bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata, bus.count);
        end
        step();
        tests++;
        if (bus.empty !== 1'b1 || bus.mem_write !== 1'b0) begin
            fails++;
            $display("FAIL sd_empty empty=%b mw=%b want 1 0", bus.empty, bus.mem_write);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010);
        #1;
        tests++;
        if (bus.ld_data !== 16'hBEEF || bus.ld_fwd !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0010) begin
            fails++;
            $display("FAIL sd_load ld=%h fwd=%b mr=%b addr=%h want beef 0 1 0010", bus.ld_data, bus.ld_fwd, bus.mem_read, bus.mem_addr);
        end
        step();
    endtask

    task automatic test_forward();
        drive(1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0020);
        step();
        bus.st_data = 16'h2222;
        #1;
        tests++;
        if (bus.ld_data !== 16'h1111 || bus.ld_fwd !== 1'b1 || bus.mem_write !== 1'b0) begin
            fails++;
            $display("FAIL fwd_first ld=%h fwd=%b mw=%b want 1111 1 0", bus.ld_data, bus.ld_fwd, bus.mem_write);
        end
        step();
        bus.st_valid = 1'b0;
        #1;
        tests++;
        if (bus.ld_data !== 16'h2222 || bus.ld_fwd !== 1'b1 || bus.mem_write !== 1'b0 || bus.count !== 3'd2) begin
            fails++;
            $display("FAIL fwd_youngest ld=%h fwd=%b mw=%b count=%0d want 2222 1 0 2", bus.ld_data, bus.ld_fwd, bus.mem_write, bus.count);
        end
        bus.ld_valid = 1'b0;
        step();
        step();
        tests++;
        if (bus.empty !== 1'b1 || mem[8'h20] !== 16'h2222) begin
            fails++;
            $display("FAIL fwd_final empty=%b mem20=%h want 1 2222", bus.empty, mem[8'h20]);
        end
    endtask

    task automatic test_full();
        int base = wlog.size();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(i), 16'hA000 + 16'(i), 1'b1, 16'h0099);
            step();
        end
        drive(1'b1, 16'h0004, 16'hA004, 1'b1, 16'h0099);
        #1;
        tests++;
        if (bus.count !== 3'd4 || bus.st_ready !== 1'b0 || bus.mem_write !== 1'b0) begin
            fails++;
            $display("FAIL full_state count=%0d st_ready=%b mw=%b want 4 0 0", bus.count, bus.st_ready, bus.mem_write);
        end
        step();
        tests++;
        if (bus.count !== 3'd4) begin
            fails++;
            $display("FAIL full_hold count=%0d want 4", bus.count);
        end
        bus.ld_valid = 1'b0;
        #1;
        tests++;
        if (bus.mem_write !== 1'b1 || bus.mem_addr !== 16'h0000 || bus.st_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_drain0 mw=%b addr=%h st_ready=%b want 1 0000 0", bus.mem_write, bus.mem_addr, bus.st_ready);
        end
        step();
        tests++;
        if (bus.count !== 3'd3 || bus.st_ready !== 1'b1 || bus.mem_addr !== 16'h0001) begin
            fails++;
            $display("FAIL full_after_drain count=%0d st_ready=%b addr=%h want 3 1 0001", bus.count, bus.st_ready, bus.mem_addr);
        end
        step();
        bus.st_valid = 1'b0;
        #1;
        tests++;
        if (bus.count !== 3'd3 || bus.mem_addr !== 16'h0002) begin
            fails++;
            $display("FAIL full_fifth_in count=%0d addr=%h want 3 0002", bus.count, bus.mem_addr);
        end
        for (int i = 0; i < 3; i++) step();
        tests++;
        if (bus.empty !== 1'b1 || wlog.size() != base + 5) begin
            fails++;
            $display("FAIL full_count empty=%b writes=%0d want 1 5", bus.empty, wlog.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (wlog[base + i] !== {16'(i), 16'hA000 + 16'(i)}) begin
                    fails++;
                    $display("FAIL full_order[%0d] got=%h want=%h", i, wlog[base + i], {16'(i), 16'hA000 + 16'(i)});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int base = wlog.size();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0040 + 16'(i), 16'hB040 + 16'(i), 1'b1, 16'h0099);
            step();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0043 + 16'(i), 16'hB043 + 16'(i), 1'b0, 16'h0);
            #1;
            tests++;
            if (bus.count !== 3'd2 || bus.mem_write !== 1'b1 || bus.mem_addr !== 16'h0041 + 16'(i) || bus.st_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b[%0d] count=%0d mw=%b addr=%h st_ready=%b want 2 1 %h 1",
                         i, bus.count, bus.mem_write, bus.mem_addr, bus.st_ready, 16'h0041 + 16'(i));
            end
            step();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0044);
        #1;
        tests++;
        if (bus.count !== 3'd2 || bus.ld_data !== 16'hB044 || bus.ld_fwd !== 1'b1) begin
            fails++;
            $display("FAIL b2b_wrap count=%0d ld=%h fwd=%b want 2 b044 1", bus.count, bus.ld_data, bus.ld_fwd);
        end
        bus.ld_valid = 1'b0;
        step();
        step();
        tests++;
        if (bus.empty !== 1'b1 || wlog.size() != base + 6 || wlog[base + 5] !== 32'h0045B045 || wlog[base + 3] !== 32'h0043B043) begin
            fails++;
            $display("FAIL b2b_order empty=%b writes=%0d want 1 6", bus.empty, wlog.size() - base);
        end
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 16'h0030, 16'h0005, 1'b0, 16'h0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        step();
        drive(1'b1, 16'h0030, 16'h0777, 1'b1, 16'h0030);
        #1;
        tests++;
        if (bus.ld_data !== 16'h0005 || bus.ld_fwd !== 1'b0) begin
            fails++;
            $display("FAIL same_cycle ld=%h fwd=%b want 0005 0", bus.ld_data, bus.ld_fwd);
        end
        step();
        bus.st_valid = 1'b0;
        #1;
        tests++;
        if (bus.ld_data !== 16'h0777 || bus.ld_fwd !== 1'b1) begin
            fails++;
            $display("FAIL next_cycle ld=%h fwd=%b want 0777 1", bus.ld_data, bus.ld_fwd);
        end
        bus.ld_valid = 1'b0;
        #1;
        tests++;
        if (bus.ld_data !== 16'h0 || bus.ld_fwd !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b1) begin
            fails++;
            $display("FAIL no_load ld=%h fwd=%b mr=%b mw=%b want 0 0 0 1", bus.ld_data, bus.ld_fwd, bus.mem_read, bus.mem_write);
        end
        step();
        tests++;
        if (bus.empty !== 1'b1 || mem[8'h30] !== 16'h0777) begin
            fails++;
            $display("FAIL same_final empty=%b mem30=%h want 1 0777", bus.empty, mem[8'h30]);
        end
    endtask

    initial begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        test_reset();
        test_store_drain();
        test_forward();
        test_full();
        test_back_to_back();
        test_same_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
